// File: rtl/alu_issue_stage.sv
// Decode-to-ALU issue stage. It decodes a RISC-V instruction into ALU operands and an
// operation code, then holds the result in a two-entry output/skid buffer with valid/ready.
module alu_issue_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int PC_WIDTH      = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              instr,
  input  logic [DATA_WIDTH-1:0]    rs1_data,
  input  logic [DATA_WIDTH-1:0]    rs2_data,
  input  logic [PC_WIDTH-1:0]      pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [PC_WIDTH-1:0]      PcFour,
  output logic [4:0]               rd,
  output logic                     reg_write,
  output logic                     branch,
  output logic                     branch_inv,
  output logic                     illegal
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    src_a;
    logic [DATA_WIDTH-1:0]    src_b;
    logic [OPCODE_LENGTH-1:0] op;
    logic [PC_WIDTH-1:0]      pc_four;
    logic [4:0]               rd;
    logic                     reg_write;
    logic                     branch;
    logic                     branch_inv;
    logic                     illegal;
  } op_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state_q, state_d;
  op_t    out_q, out_d, skid_q, skid_d, dec;
  logic   in_ready_q, in_ready_d;
  logic   accept, legal, wr;

  logic [6:0]            opc;
  logic [2:0]            f3;
  logic [6:0]            f7;
  logic [DATA_WIDTH-1:0] imm_i, imm_s, shamt;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign imm_i = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign shamt = {{(DATA_WIDTH-5){1'b0}}, instr[24:20]};

  always_comb begin
    dec         = '0;
    dec.pc_four = pc + PC_WIDTH'(4);
    dec.rd      = instr[11:7];
    dec.src_a   = rs1_data;
    legal       = 1'b1;
    wr          = 1'b0;
    case (opc)
      7'b0110011: begin
        dec.src_b = rs2_data;
        wr        = 1'b1;
        case ({f7, f3})
          {7'h00, 3'b000}: dec.op = 4'b0010;
          {7'h20, 3'b000}: dec.op = 4'b1010;
          {7'h00, 3'b111}: dec.op = 4'b0000;
          {7'h00, 3'b110}: dec.op = 4'b0101;
          {7'h00, 3'b100}: dec.op = 4'b0001;
          {7'h00, 3'b010}: dec.op = 4'b1100;
          default:         legal  = 1'b0;
        endcase
      end
      7'b0010011: begin
        dec.src_b = imm_i;
        wr        = 1'b1;
        case (f3)
          3'b000: dec.op = 4'b1011;
          3'b010: dec.op = 4'b0011;
          3'b111: dec.op = 4'b0000;
          3'b110: dec.op = 4'b0101;
          3'b100: dec.op = 4'b0001;
          3'b001: begin
            dec.src_b = shamt;
            dec.op    = 4'b0110;
            legal     = (f7 == 7'h00);
          end
          3'b101: begin
            dec.src_b = shamt;
            dec.op    = f7[5] ? 4'b0111 : 4'b1110;
            legal     = (f7 == 7'h00) || (f7 == 7'h20);
          end
          default: legal = 1'b0;
        endcase
      end
      7'b0000011: begin dec.src_b = imm_i; dec.op = 4'b0010; wr = 1'b1; end
      7'b0100011: begin dec.src_b = imm_s; dec.op = 4'b0010; end
      7'b1100011: begin
        dec.src_b      = rs2_data;
        dec.op         = 4'b1000;
        dec.branch     = 1'b1;
        dec.branch_inv = f3[0];
        legal          = (f3 == 3'b000) || (f3 == 3'b001);
      end
      7'b1100111: begin dec.src_b = imm_i; dec.op = 4'b0100; wr = 1'b1; end
      default:    legal = 1'b0;
    endcase
    // Illegal ops still flow downstream, but as a harmless, non-writing bubble.
    if (!legal) begin
      dec.src_a      = '0;
      dec.src_b      = '0;
      dec.op         = '0;
      dec.branch     = 1'b0;
      dec.branch_inv = 1'b0;
      dec.illegal    = 1'b1;
    end else begin
      dec.reg_write = wr && (instr[11:7] != 5'd0);
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    accept  = in_valid && in_ready_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin out_d = dec; state_d = ONE; end
        ONE: begin
          if (accept && out_ready) out_d = dec;
          else if (accept) begin skid_d = dec; state_d = FULL; end
          else if (out_ready) state_d = EMPTY;
        end
        FULL: if (out_ready) begin out_d = skid_q; state_d = ONE; end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != EMPTY);
  assign SrcA       = out_q.src_a;
  assign SrcB       = out_q.src_b;
  assign Operation  = out_q.op;
  assign PcFour     = out_q.pc_four;
  assign rd         = out_q.rd;
  assign reg_write  = out_q.reg_write;
  assign branch     = out_q.branch;
  assign branch_inv = out_q.branch_inv;
  assign illegal    = out_q.illegal;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Instruction-decode to ALU issue stage, the producer side of the ALU operand/operation interface.
- Decodes a RISC-V instruction into the 4-bit ALU Operation code and selects SrcA/SrcB/PcFour from register data, immediates and PC.
- Buffers each decoded op in a two-entry skid buffer with valid/ready handshakes on both sides.
- Sits between register-file read and the ALU.

Parameters:
- DATA_WIDTH, 32, operand width.
- OPCODE_LENGTH, 4, ALU operation code width.
- PC_WIDTH, 9, width of pc and PcFour.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous: discards all buffered ops.
- in_valid  in  1  upstream offers instr/operands.
- in_ready  out  1  stage can accept; registered.
- instr  in  32  RISC-V instruction.
- rs1_data  in  DATA_WIDTH  register rs1 value.
- rs2_data  in  DATA_WIDTH  register rs2 value.
- pc  in  PC_WIDTH  instruction address.
- out_valid  out  1  ALU-side op valid.
- out_ready  in  1  ALU/EX consumes op.
- SrcA, SrcB  out  DATA_WIDTH  ALU operands.
- Operation  out  OPCODE_LENGTH  ALU operation code.
- PcFour  out  PC_WIDTH  pc+4, used by JALR.
- rd  out  5  destination register, instr[11:7].
- reg_write  out  1  writeback enable.
- branch  out  1  conditional branch op.
- branch_inv  out  1  branch taken when ALUResult==0 (BNE).
- illegal  out  1  undecodable instruction.

Behaviour:
- Reset (reset=0, async): out_valid=0, in_ready=1, skid empty, all data outputs 0.
- Decode is combinational on the inputs and is captured on acceptance (in_valid && in_ready).
- Latency: 1 cycle from acceptance to out_valid when the output register is free.
- Decode map (SrcA=rs1_data unless noted):
  - R-type (0110011), SrcB=rs2_data: ADD 0010, SUB (funct7=0100000) 1010, AND 0000, OR 0101, XOR 0001, SLT 1100. Any other funct3/funct7 is illegal.
  - I-type (0010011), SrcB=sign-extended instr[31:20]: ADDI 1011, SLTI 0011, ANDI 0000, ORI 0101, XORI 0001.
  - Shift immediates, SrcB=zero-extended instr[24:20]: SLLI 0110, SRLI 1110, SRAI (funct7=0100000) 0111. A bad funct7 is illegal.
  - Load (0000011): ADD 0010, I-immediate.
  - Store (0100011): ADD 0010, S-immediate {instr[31:25],instr[11:7]} sign-extended, reg_write=0.
  - Branch (1100011), SrcB=rs2_data, Operation 1000 (EQUAL), branch=1: BEQ (funct3 000) branch_inv=0; BNE (001) branch_inv=1. Other funct3 values are illegal.
  - JALR (1100111): Operation 0100, SrcB=I-immediate.
- PcFour = pc+4 modulo 2^PC_WIDTH; wraps, e.g. 0x1FC -> 0x000.
- reg_write=1 for R, I, load and JALR only when rd!=0. Otherwise 0.
- Illegal instruction: Operation=0000, SrcA=SrcB=0, reg_write=0, branch=0, illegal=1. The op is still passed through with out_valid.
- Skid buffer states:
  - EMPTY: out_valid=0. Accept loads the output register and moves to ONE.
  - ONE: out_valid=1.
    - Accept with out_ready=1: replaces the output register, stays ONE.
    - Accept with out_ready=0: loads the skid register, moves to FULL; in_ready=0 from the next cycle.
    - No accept with out_ready=1: moves to EMPTY.
  - FULL: in_ready=0. out_ready=1 moves skid to output, moves to ONE; in_ready=1 from the next cycle.
- Output fields are held stable while out_valid && !out_ready.
- Ordering is strictly FIFO.
- flush=1 at an edge:
  - Next state is EMPTY, out_valid=0, in_ready=1.
  - Any same-cycle input is dropped.
  - flush wins over accept.
- Reset asserted mid-operation: immediate return to the reset state; buffered ops are lost.

Test Plan:
- Reset, then add x5,x1,x2 with rs1=7, rs2=5, out_ready=1 -> next cycle out_valid=1, Operation=0010, SrcA=7, SrcB=5, rd=5, reg_write=1.
- srai x3,x4,3 with rs1=0x80000000 -> Operation=0111, SrcB=3.
- addi x1,x0,-1 -> Operation=1011, SrcB=0xFFFFFFFF.
- bne, pc=0x1FC -> Operation=1000, branch=1, branch_inv=1, reg_write=0, SrcB=rs2.
- jalr x1,0(x2), pc=0x1FC -> Operation=0100, PcFour=0x000, reg_write=1.
- Hold out_ready=0, issue 3 back-to-back ops A,B,C:
  - A held on the output; B in skid; in_ready=0; C not accepted.
  - Raise out_ready -> outputs A, B, C in order with no loss or duplication.
- In FULL state assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing emitted.
- Undefined opcode 0x0000007F -> illegal=1, Operation=0000, reg_write=0.
- Assert reset while FULL -> out_valid=0 immediately, in_ready=1.
